// File: rtl/cam_capture.sv
`default_nettype none
// ============================================================================
// Module   : cam_capture
// Brief    : OV7670-style RGB565 byte-pair capture with format conversion,
//            2:1 decimation and arm/continuous control; frame buffer writer.
// Revision : 1.0  initial release
// ============================================================================
module cam_capture #(
    parameter int AW    = 15,
    parameter int DW    = 16,
    parameter int IMG_W = 160,
    parameter int IMG_H = 120
) (
    input  logic          pclk_i,
    input  logic          rst_i,
    input  logic          vsync_i,
    input  logic          href_i,
    input  logic [7:0]    px_data_i,
    input  logic [1:0]    mode_i,
    input  logic          dec_i,
    input  logic          cont_i,
    input  logic          arm_i,
    output logic [AW-1:0] mem_px_addr_o,
    output logic [DW-1:0] mem_px_data_o,
    output logic          px_wr_o,
    output logic          frame_done_o,
    output logic [7:0]    frame_cnt_o,
    output logic          overflow_o,
    output logic          busy_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_VS = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    localparam logic [AW-1:0] C_ADDR_LIM = AW'(IMG_W * IMG_H);
    localparam logic [15:0]   C_IMG_W    = 16'(IMG_W);
    localparam logic [15:0]   C_IMG_H    = 16'(IMG_H);

    state_t        state_q, state_d;
    logic          vs_prev_q, href_prev_q;
    logic [1:0]    mode_q;
    logic          dec_q, phase_q, arm_pend_q;
    logic [7:0]    hi_q;
    logic [15:0]   col_q, row_q;
    logic [AW-1:0] addr_q, out_addr_q;
    logic [DW-1:0] out_data_q;
    logic          wr_q, done_q, ovf_q;
    logic [7:0]    cnt_q;

    logic          w_vs_fall, w_vs_rise, w_href_fall;
    logic [15:0]   w_pix, w_col_s, w_row_s, w_conv;
    logic          w_keep, w_wcond;
    logic [7:0]    w_r8, w_g8, w_b8;
    logic [9:0]    w_gsum;

    assign w_vs_fall   = vs_prev_q & ~vsync_i;
    assign w_vs_rise   = ~vs_prev_q & vsync_i;
    assign w_href_fall = href_prev_q & ~href_i;
    assign w_pix       = {hi_q, px_data_i};

    // Bounds are tested on the decimated coordinate so the limits stay IMG_W/IMG_H.
    assign w_col_s = dec_q ? (col_q >> 1) : col_q;
    assign w_row_s = dec_q ? (row_q >> 1) : row_q;
    assign w_keep  = ~dec_q | (~col_q[0] & ~row_q[0]);
    assign w_wcond = (state_q == S_CAPTURE) && href_i && phase_q && w_keep
                     && (w_col_s < C_IMG_W) && (w_row_s < C_IMG_H);

    assign w_r8   = {w_pix[15:11], w_pix[15:13]};
    assign w_g8   = {w_pix[10:5],  w_pix[10:9]};
    assign w_b8   = {w_pix[4:0],   w_pix[4:2]};
    assign w_gsum = {2'b00, w_r8} + {1'b0, w_g8, 1'b0} + {2'b00, w_b8};

    always_comb begin
        w_conv = w_pix;
        case (mode_q)
            2'd0:    w_conv = {8'h00, w_pix[15:13], w_pix[10:8], w_pix[4:3]};
            2'd1:    w_conv = {4'h0, w_pix[15:12], w_pix[10:7], w_pix[4:1]};
            2'd2:    w_conv = w_pix;
            default: w_conv = {8'h00, w_gsum[9:2]};
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (arm_i || cont_i) state_d = S_WAIT_VS;
            S_WAIT_VS: if (w_vs_fall) state_d = S_CAPTURE;
            S_CAPTURE: if (w_vs_rise)
                           state_d = (cont_i || arm_pend_q || arm_i) ? S_WAIT_VS : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge pclk_i) begin
        if (rst_i) begin
            vs_prev_q   <= 1'b0;
            href_prev_q <= 1'b0;
            mode_q      <= 2'd0;
            dec_q       <= 1'b0;
            phase_q     <= 1'b0;
            arm_pend_q  <= 1'b0;
            hi_q        <= 8'h00;
            col_q       <= 16'd0;
            row_q       <= 16'd0;
            addr_q      <= '0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            wr_q        <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            cnt_q       <= 8'd0;
        end else begin
            vs_prev_q   <= vsync_i;
            href_prev_q <= href_i;
            wr_q        <= 1'b0;
            done_q      <= 1'b0;

            if (state_q == S_WAIT_VS && w_vs_fall) begin
                mode_q     <= mode_i;
                dec_q      <= dec_i;
                addr_q     <= '0;
                col_q      <= 16'd0;
                row_q      <= 16'd0;
                phase_q    <= 1'b0;
                ovf_q      <= 1'b0;
                arm_pend_q <= 1'b0;
            end

            if (state_q == S_CAPTURE) begin
                if (arm_i) arm_pend_q <= 1'b1;
                if (href_i) begin
                    if (!phase_q) begin
                        hi_q    <= px_data_i;
                        phase_q <= 1'b1;
                    end else begin
                        phase_q <= 1'b0;
                        if (col_q != 16'hFFFF) col_q <= col_q + 16'd1;
                        if (w_wcond) begin
                            if (addr_q == C_ADDR_LIM) begin
                                ovf_q <= 1'b1;
                            end else begin
                                wr_q       <= 1'b1;
                                out_addr_q <= addr_q;
                                out_data_q <= DW'(w_conv);
                                addr_q     <= addr_q + 1'b1;
                            end
                        end
                    end
                end else if (w_href_fall) begin
                    col_q   <= 16'd0;
                    phase_q <= 1'b0;
                    if (row_q != 16'hFFFF) row_q <= row_q + 16'd1;
                end
                // Pending arm is consumed by the frame end it belongs to.
                if (w_vs_rise) begin
                    done_q     <= 1'b1;
                    cnt_q      <= cnt_q + 8'd1;
                    arm_pend_q <= 1'b0;
                end
            end
        end
    end

    assign mem_px_addr_o = out_addr_q;
    assign mem_px_data_o = out_data_q;
    assign px_wr_o       = wr_q;
    assign frame_done_o  = done_q;
    assign frame_cnt_o   = cnt_q;
    assign overflow_o    = ovf_q;
    assign busy_o        = (state_q == S_WAIT_VS) || (state_q == S_CAPTURE);

endmodule
`default_nettype wire

// File: tb/tb_cam_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_cam_capture
// Brief    : Scoreboard bench for cam_capture (IMG_W=4, IMG_H=2).
// Revision : 1.0  initial release
// ============================================================================
module tb_cam_capture;

    localparam int AW = 15;
    localparam int DW = 16;
    localparam int W  = 4;
    localparam int H  = 2;

    logic          pclk = 1'b0;
    logic          rst, vsync, href, dec, cont, arm;
    logic [7:0]    px_data;
    logic [1:0]    mode;
    logic [AW-1:0] mem_px_addr;
    logic [DW-1:0] mem_px_data;
    logic          px_wr, frame_done, overflow, busy;
    logic [7:0]    frame_cnt;

    always #5 pclk = ~pclk;

    cam_capture #(.AW(AW), .DW(DW), .IMG_W(W), .IMG_H(H)) u_dut (
        .pclk_i        (pclk),
        .rst_i         (rst),
        .vsync_i       (vsync),
        .href_i        (href),
        .px_data_i     (px_data),
        .mode_i        (mode),
        .dec_i         (dec),
        .cont_i        (cont),
        .arm_i         (arm),
        .mem_px_addr_o (mem_px_addr),
        .mem_px_data_o (mem_px_data),
        .px_wr_o       (px_wr),
        .frame_done_o  (frame_done),
        .frame_cnt_o   (frame_cnt),
        .overflow_o    (overflow),
        .busy_o        (busy)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [15:0]   d;
        int            c;
    } exp_t;

    exp_t        sb[$];
    exp_t        m_e;
    logic [15:0] pat[$];
    int          n_chk   = 0;
    int          n_err   = 0;
    int          cyc     = 0;
    int          fd_seen = 0;
    int          fexp    = 0;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(negedge pclk) begin
        if (frame_done) fd_seen++;
        if (px_wr) begin
            if (sb.size() == 0) begin
                check_val("unexpected_wr", 32'd1, 32'd0);
            end else begin
                m_e = sb.pop_front();
                check_val("wr_addr", 32'(mem_px_addr), 32'(m_e.a));
                check_val("wr_data", 32'(mem_px_data), 32'(m_e.d));
                check_val("wr_cycle", cyc, m_e.c);
            end
        end
    end

    function automatic logic [15:0] conv(input logic [1:0] m, input logic [15:0] p);
        int r8, g8, b8;
        r8 = {p[15:11], p[15:13]};
        g8 = {p[10:5], p[10:9]};
        b8 = {p[4:0], p[4:2]};
        case (m)
            2'd0:    return {8'h00, p[15:13], p[10:8], p[4:3]};
            2'd1:    return {4'h0, p[15:12], p[10:7], p[4:1]};
            2'd2:    return p;
            default: return 16'((r8 + 2 * g8 + b8) >> 2);
        endcase
    endfunction

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // mid_act: 1 = pulse arm on the first byte, 2 = clear cont on the first byte
    task automatic drive_frame(input int lines, input int bytes, input bit cap, input int mid_act);
        int          a, pidx, c;
        logic [15:0] p;
        bit          d;
        logic [1:0]  m;
        a = 0; pidx = 0; d = dec; m = mode;
        vsync = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        repeat (2) tick();
        for (int r = 0; r < lines; r++) begin
            href = 1'b1;
            if (r == 0 && mid_act == 1) arm = 1'b1;
            if (r == 0 && mid_act == 2) cont = 1'b0;
            for (int b = 0; b < bytes; b++) begin
                p = pat[pidx % pat.size()];
                if (b % 2 == 0) begin
                    px_data = p[15:8];
                end else begin
                    px_data = p[7:0];
                    c = b / 2;
                    if (cap && (!d || (c % 2 == 0 && r % 2 == 0)) && ((c >> d) < W)
                        && ((r >> d) < H) && a < W * H) begin
                        sb.push_back('{a: AW'(a), d: conv(m, p), c: cyc + 1});
                        a++;
                    end
                    pidx++;
                end
                tick();
                arm = 1'b0;
            end
            href = 1'b0;
            px_data = 8'h00;
            repeat (3) tick();
        end
        vsync = 1'b1;
        tick();
        if (cap) fexp++;
        repeat (3) tick();
        check_val("frame_cnt", 32'(frame_cnt), fexp);
        check_val("frame_done_cnt", fd_seen, fexp);
        check_val("overflow", 32'(overflow), 32'd0);
        check_val("sb_drain", sb.size(), 32'd0);
    endtask

    initial begin
        rst = 1'b1; vsync = 1'b1; href = 1'b0; px_data = 8'h00;
        mode = 2'd2; dec = 1'b0; cont = 1'b0; arm = 1'b0;
        repeat (3) tick();
        @(negedge pclk);
        check_val("rst_px_wr", 32'(px_wr), 32'd0);
        check_val("rst_addr", 32'(mem_px_addr), 32'd0);
        check_val("rst_data", 32'(mem_px_data), 32'd0);
        check_val("rst_cnt", 32'(frame_cnt), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_ovf", 32'(overflow), 32'd0);
        tick();
        rst = 1'b0;

        // RGB565 passthrough, 2 lines x 4 pixels
        pat = {};
        for (int i = 1; i <= 16; i++) pat.push_back(16'(i));
        cont = 1'b1;
        drive_frame(2, 8, 1'b1, 0);

        mode = 2'd0; pat = {16'hF800, 16'h07E0, 16'h001F, 16'hFFFF};
        drive_frame(1, 8, 1'b1, 0);
        mode = 2'd3; pat = {16'hFFFF, 16'h0000, 16'hF800, 16'h1234};
        drive_frame(1, 8, 1'b1, 0);
        mode = 2'd1; pat = {16'hABCD, 16'h1357, 16'h8642, 16'hF0F0};
        drive_frame(2, 8, 1'b1, 0);

        // decimation with rows beyond the limit; odd-length and long lines
        mode = 2'd2; dec = 1'b1;
        pat = {};
        for (int i = 0; i < 32; i++) pat.push_back(16'(16'h0100 + i * 3));
        drive_frame(6, 16, 1'b1, 0);
        dec = 1'b0;
        drive_frame(4, 9, 1'b1, 0);
        drive_frame(3, 12, 1'b1, 0);

        // clearing cont mid-frame ends continuous capture after that frame
        drive_frame(1, 8, 1'b1, 2);
        @(negedge pclk);
        check_val("busy_after_cont_clr", 32'(busy), 32'd0);
        drive_frame(1, 8, 1'b0, 0);

        // single shot
        tick();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        @(negedge pclk);
        check_val("busy_armed", 32'(busy), 32'd1);
        drive_frame(2, 8, 1'b1, 0);
        drive_frame(2, 8, 1'b0, 0);
        drive_frame(2, 8, 1'b0, 0);
        @(negedge pclk);
        check_val("busy_single_shot", 32'(busy), 32'd0);

        // arm during a frame captures exactly one more
        tick();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        drive_frame(1, 8, 1'b1, 1);
        drive_frame(1, 8, 1'b1, 0);
        drive_frame(1, 8, 1'b0, 0);

        // reset in the middle of a line
        cont = 1'b1;
        vsync = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        repeat (2) tick();
        href = 1'b1; px_data = 8'h55; rst = 1'b1;
        tick();
        @(negedge pclk);
        check_val("midrst_px_wr", 32'(px_wr), 32'd0);
        check_val("midrst_addr", 32'(mem_px_addr), 32'd0);
        check_val("midrst_busy", 32'(busy), 32'd0);
        check_val("midrst_cnt", 32'(frame_cnt), 32'd0);
        fexp = 0; fd_seen = 0;
        tick();
        rst = 1'b0; href = 1'b0; cont = 1'b0;
        drive_frame(1, 8, 1'b0, 0);
        cont = 1'b1;
        pat = {16'h2222, 16'h3333, 16'h4444, 16'h5555};
        drive_frame(2, 8, 1'b1, 0);

        check_val("sb_final", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
